// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for ctrl=101.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    input  logic             flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             flag_q, flag_d;

    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic             sov;
    logic [SHW-1:0]   sh;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     psum;

    // Partial product added into the upper half, then the whole pair shifts right.
    assign psum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif

    // Subtraction reuses the adder as a + ~b + 1.
    assign bop = flag ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, flag};
    assign sov = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    assign sh  = b[SHW-1:0];

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;
`ifdef ALU_MUL_EN
        mcand_d = mcand_q;
        prod_d  = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ctrl_d  = ctrl;
                    flag_d  = flag;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                    case (ctrl)
                        3'b000: begin
                            res_d = sum[WIDTH-1:0];
                            ovf_d = flag ? sov : sum[WIDTH];
                        end
                        3'b001: res_d = flag ? ~(a & b) : ~(a | b);
                        3'b010: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
                        3'b011, 3'b100: begin
                            res_d = a;
                            cnt_d = {1'b0, sh};
                            if (sh != '0) state_d = BUSY;
                        end
`ifdef ALU_MUL_EN
                        3'b101: begin
                            mcand_d = a;
                            prod_d  = {{WIDTH{1'b0}}, b};
                            cnt_d   = CW'(WIDTH);
                            state_d = BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
`ifdef ALU_MUL_EN
                if (ctrl_q == 3'b101) begin
                    prod_d = {psum, prod_q[WIDTH-1:1]};
                    if (cnt_q == CW'(1)) begin
                        res_d = prod_d[WIDTH-1:0];
                        ovf_d = |prod_d[2*WIDTH-1:WIDTH];
                    end
                end else
`endif
                if (ctrl_q == 3'b100) begin
                    res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
                end else if (flag_q) begin
                    res_d = {res_q[WIDTH-2:0], 1'b0};
                end else begin
                    res_d = {1'b0, res_q[WIDTH-1:1]};
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q <= '0;
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
`ifdef ALU_MUL_EN
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=16).
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  ctrl;
    logic        flag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        zero;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ctrl     (ctrl),
        .flag     (flag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow),
        .zero     (zero)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                   input logic [2:0] c, input logic f);
        exp_t               e;
        logic [16:0]        s;
        logic signed [15:0] t;
        int                 sh;
`ifdef ALU_MUL_EN
        logic [31:0]        p;
`endif
        e.res = '0;
        e.ovf = 1'b0;
        e.lat = 1;
        sh    = int'(bb[3:0]);
        t     = aa;
        case (c)
            3'd0: begin
                if (!f) begin
                    s     = {1'b0, aa} + {1'b0, bb};
                    e.res = s[15:0];
                    e.ovf = s[16];
                end else begin
                    e.res = aa - bb;
                    e.ovf = (aa[15] ^ bb[15]) & (aa[15] ^ e.res[15]);
                end
            end
            3'd1: e.res = f ? ~(aa & bb) : ~(aa | bb);
            3'd2: e.res = (aa < bb) ? 16'd1 : 16'd0;
            3'd3: begin
                e.res = f ? (aa << sh) : (aa >> sh);
                e.lat = sh + 1;
            end
            3'd4: begin
                e.res = t >>> sh;
                e.lat = sh + 1;
            end
`ifdef ALU_MUL_EN
            3'd5: begin
                p     = {16'd0, aa} * {16'd0, bb};
                e.res = p[15:0];
                e.ovf = |p[31:16];
                e.lat = 17;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic [2:0] tc, input logic tf, input int hold);
        exp_t e;
        int   lat;
        bit   ok;
        bit   rdy_seen;
        @(negedge clk);
        a        = ta;
        b        = tb;
        ctrl     = tc;
        flag     = tf;
        in_valid = 1'b1;
        sb.push_back(model(ta, tb, tc, tf));
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        ctrl     = 3'($urandom);
        lat      = 1;
        ok       = 1'b0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) rdy_seen = 1'b1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check("done_timeout", 32'(ok), 32'd1);
        check("in_ready_busy", 32'(rdy_seen), 32'd0);
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("result", 32'(result), 32'(e.res));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("zero", 32'(zero), 32'(e.res == 16'd0));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = 16'h0001;
            b        = 16'h0001;
            ctrl     = 3'b000;
            flag     = 1'b0;
            @(negedge clk);
            check("hold_result", 32'(result), 32'(e.res));
            check("hold_ovf_zero", 32'({overflow, zero}),
                  32'({e.ovf, e.res == 16'd0}));
            check("hold_hs", 32'({out_valid, in_ready}), 32'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_hs", 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        bit vis;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ctrl      = '0;
        flag      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hs", 32'({out_valid, in_ready}), 32'b01);
        check("rst_res", 32'({result, overflow, zero}), 32'h00001);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_oready", 32'({out_valid, in_ready}), 32'b01);
        out_ready = 1'b0;

        run_op(16'hFFFF, 16'h0001, 3'b000, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 3'b000, 1'b1, 0);
        run_op(16'h0005, 16'h0003, 3'b000, 1'b1, 0);
        run_op(16'h8000, 16'h0003, 3'b100, 1'b0, 0);
        run_op(16'h8000, 16'h0003, 3'b011, 1'b0, 0);
        run_op(16'h0001, 16'h000F, 3'b011, 1'b1, 0);
        run_op(16'hA5A5, 16'h0000, 3'b100, 1'b0, 0);
        run_op(16'hF0F0, 16'h0FF0, 3'b001, 1'b1, 5);
        run_op(16'h0001, 16'h0001, 3'b000, 1'b0, 0);
        run_op(16'hF0F0, 16'h0F0F, 3'b001, 1'b0, 0);
        run_op(16'h0003, 16'h0004, 3'b010, 1'b0, 0);
        run_op(16'h0100, 16'h0100, 3'b101, 1'b0, 0);
        run_op(16'h0003, 16'h0007, 3'b101, 1'b1, 0);
        run_op(16'h1234, 16'h5678, 3'b110, 1'b0, 0);
        run_op(16'h1234, 16'h5678, 3'b111, 1'b1, 2);

        @(negedge clk);
        a        = 16'h1234;
        b        = 16'h000F;
        ctrl     = 3'b011;
        flag     = 1'b1;
        in_valid = 1'b1;
        check("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        vis = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) vis = 1'b1;
            if (i == 5) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy_valid", 32'(vis), 32'd0);
        check("abort_hs", 32'({out_valid, in_ready}), 32'b01);
        check("abort_res", 32'({result, zero}), 32'h00001);
        run_op(16'h0102, 16'h0304, 3'b000, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            run_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
